// File: rtl/icache_dm_burst_if.sv
// -----------------------------------------------------------------------------
// icache_dm_burst_if
//
// Bundles the fetch-side request/response channels and the backing-memory
// read bus of the direct-mapped instruction cache.
//
// Handshake rules:
//   * Fetch request:  an address transfers on a rising edge where
//                     cache_valid_in & cache_ready_out are both high.
//   * Fetch response: a byte transfers on a rising edge where
//                     cache_valid_out & cache_ready_in are both high; while
//                     the consumer stalls, valid and data stay stable.
//   * Memory read:    memory_stb stays high with a stable memory_addr until
//                     memory_ack is seen; memory_data is qualified by
//                     memory_ack, and an ack while memory_stb=0 is ignored.
//
// Modports:
//   slave  - the cache controller's view (answers fetch, drives memory reads)
//   master - the environment's view (fetch unit plus memory model)
// -----------------------------------------------------------------------------
interface icache_dm_burst_if #(
    parameter int ADDR_WIDTH = 16
);
    // fetch request channel
    logic                    cache_ready_out;
    logic                    cache_valid_in;
    logic [ADDR_WIDTH-1:0]   cache_addr_in;
    // fetch response channel
    logic                    cache_ready_in;
    logic                    cache_valid_out;
    logic [7:0]              cache_data_out;
    // backing memory read bus (word addressed)
    logic                    memory_stb;
    logic [ADDR_WIDTH-3:0]   memory_addr;
    logic [31:0]             memory_data;
    logic                    memory_ack;

    modport slave (
        input  cache_valid_in, cache_addr_in, cache_ready_in,
        input  memory_data, memory_ack,
        output cache_ready_out, cache_valid_out, cache_data_out,
        output memory_stb, memory_addr
    );

    modport master (
        output cache_valid_in, cache_addr_in, cache_ready_in,
        output memory_data, memory_ack,
        input  cache_ready_out, cache_valid_out, cache_data_out,
        input  memory_stb, memory_addr
    );
endinterface

// File: rtl/icache_dm_burst.sv
// -----------------------------------------------------------------------------
// icache_dm_burst
//
// Direct-mapped instruction cache with 2^WORD_BITS-word lines, word-by-word
// burst refill from a 32-bit memory and an on-demand invalidation sweep.
// One byte is returned per accepted byte address; bytes are big-endian within
// a word (byte 0 = data[31:24]).
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset (restarts the INIT sweep)
//   flush        single-cycle request to invalidate every line
//   busy         sweep pending or running
//   o_dbg_state  current FSM state (INIT=0 LOOKUP=1 REFILL=2 REPLAY=3 FLUSH=4)
//   bus          fetch request/response and memory read bus (slave view)
//
// TAG_BITS = ADDR_WIDTH-INDEX_BITS-WORD_BITS-2 must be at least 1.
// -----------------------------------------------------------------------------
module icache_dm_burst #(
    parameter int ADDR_WIDTH = 16,
    parameter int INDEX_BITS = 6,
    parameter int WORD_BITS  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    output logic                busy,
    output logic [2:0]          o_dbg_state,
    icache_dm_burst_if.slave    bus
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - WORD_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << WORD_BITS;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_LOOKUP = 3'd1,
        S_REFILL = 3'd2,
        S_REPLAY = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t                  r_state, w_next_state;

    // stage register
    logic                    r_valid_buf;
    logic [TAG_BITS-1:0]     r_tag_buf;
    logic [INDEX_BITS-1:0]   r_index_buf;
    logic [WORD_BITS-1:0]    r_word_buf;
    logic [1:0]              r_byte_buf;

    logic                    r_flush_pending;
    logic [INDEX_BITS-1:0]   r_sweep_idx;
    logic [WORD_BITS-1:0]    r_word_cnt;

    // storage: valid bits, tags, data words addressed by {index, word}
    logic [LINES-1:0]        r_line_valid;
    logic [TAG_BITS-1:0]     r_tag_mem  [LINES];
    logic [31:0]             r_data_mem [LINES*WORDS];

    logic                    w_hit;
    logic [31:0]             w_word;
    logic                    w_ready_out, w_valid_out, w_stb;
    logic                    w_drain, w_sweep_clear, w_fill_write, w_enter_flush;

    // address split of the incoming request: tag | index | word | byte
    logic [TAG_BITS-1:0]     w_in_tag;
    logic [INDEX_BITS-1:0]   w_in_index;
    logic [WORD_BITS-1:0]    w_in_word;
    logic [1:0]              w_in_byte;

    assign w_in_tag   = bus.cache_addr_in[ADDR_WIDTH-1 -: TAG_BITS];
    assign w_in_index = bus.cache_addr_in[2+WORD_BITS +: INDEX_BITS];
    assign w_in_word  = bus.cache_addr_in[2 +: WORD_BITS];
    assign w_in_byte  = bus.cache_addr_in[1:0];

    // Lookup reads the arrays combinationally from the stage register, so a
    // request accepted at one edge is answered in the following cycle.
    assign w_hit  = r_valid_buf & r_line_valid[r_index_buf]
                  & (r_tag_mem[r_index_buf] == r_tag_buf);
    assign w_word = r_data_mem[{r_index_buf, r_word_buf}];

    always_comb begin
        w_next_state  = r_state;
        w_ready_out   = 1'b0;
        w_valid_out   = 1'b0;
        w_stb         = 1'b0;
        w_drain       = 1'b0;
        w_sweep_clear = 1'b0;
        w_fill_write  = 1'b0;
        w_enter_flush = 1'b0;
        case (r_state)
            S_INIT, S_FLUSH: begin
                w_sweep_clear = 1'b1;
                if (&r_sweep_idx) w_next_state = S_LOOKUP;
            end
            S_LOOKUP: begin
                w_valid_out = w_hit;
                w_ready_out = bus.cache_ready_in & (w_hit | ~r_valid_buf)
                            & ~r_flush_pending;
                // A pending flush blocks new requests; a hit that is still
                // consumed must then empty the stage so the sweep can start.
                w_drain     = w_hit & bus.cache_ready_in & ~w_ready_out;
                if (r_valid_buf && !w_hit) begin
                    w_next_state = S_REFILL;
                end else if (r_flush_pending && !r_valid_buf) begin
                    w_next_state  = S_FLUSH;
                    w_enter_flush = 1'b1;
                end
            end
            S_REFILL: begin
                w_stb        = 1'b1;
                w_fill_write = bus.memory_ack;
                if (bus.memory_ack && (&r_word_cnt)) w_next_state = S_REPLAY;
            end
            S_REPLAY: begin
                w_next_state = S_LOOKUP;
            end
            default: begin
                w_next_state = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_INIT;
            r_valid_buf     <= 1'b0;
            r_tag_buf       <= '0;
            r_index_buf     <= '0;
            r_word_buf      <= '0;
            r_byte_buf      <= '0;
            r_flush_pending <= 1'b0;
            r_sweep_idx     <= '0;
            r_word_cnt      <= '0;
        end else begin
            r_state <= w_next_state;
            // a new flush request wins over the clear on sweep entry
            r_flush_pending <= flush | (r_flush_pending & ~w_enter_flush);
            if (w_sweep_clear) r_sweep_idx <= r_sweep_idx + INDEX_BITS'(1);
            if (r_state == S_LOOKUP && w_next_state == S_REFILL) begin
                r_word_cnt <= '0;
            end else if (w_fill_write) begin
                r_word_cnt <= r_word_cnt + WORD_BITS'(1);
            end
            if (w_ready_out) begin
                r_valid_buf <= bus.cache_valid_in;
                r_tag_buf   <= w_in_tag;
                r_index_buf <= w_in_index;
                r_word_buf  <= w_in_word;
                r_byte_buf  <= w_in_byte;
            end else if (w_drain) begin
                r_valid_buf <= 1'b0;
            end
        end
    end

    // Arrays carry no reset: INIT clears every valid bit before any lookup.
    always_ff @(posedge clk) begin
        if (w_sweep_clear) r_line_valid[r_sweep_idx] <= 1'b0;
        if (w_fill_write) begin
            r_data_mem[{r_index_buf, r_word_cnt}] <= bus.memory_data;
            // invalidate on the first word so a half-filled line never hits
            if (r_word_cnt == '0) r_line_valid[r_index_buf] <= 1'b0;
            if (&r_word_cnt) begin
                r_line_valid[r_index_buf] <= 1'b1;
                r_tag_mem[r_index_buf]    <= r_tag_buf;
            end
        end
    end

    always_comb begin
        case (r_byte_buf)
            2'd0:    bus.cache_data_out = w_word[31:24];
            2'd1:    bus.cache_data_out = w_word[23:16];
            2'd2:    bus.cache_data_out = w_word[15:8];
            default: bus.cache_data_out = w_word[7:0];
        endcase
    end

    assign bus.cache_ready_out = w_ready_out;
    assign bus.cache_valid_out = w_valid_out;
    assign bus.memory_stb      = w_stb;
    assign bus.memory_addr     = {r_tag_buf, r_index_buf, r_word_cnt};
    assign busy        = r_flush_pending | (r_state == S_INIT) | (r_state == S_FLUSH);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_icache_dm_burst.sv
// -----------------------------------------------------------------------------
// tb_icache_dm_burst
//
// Directed bench for icache_dm_burst (ADDR_WIDTH=16, INDEX_BITS=6,
// WORD_BITS=2). Address 0x1234 decodes as tag 4, index 0x23, word 1, byte 0,
// so its line is refilled from word addresses 0x48C..0x48F and its byte comes
// from the second refilled word. 0x5234 shares index 0x23 with tag 20.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_icache_dm_burst;
    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_REFILL = 3'd2;
    localparam logic [2:0] ST_REPLAY = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       busy;
    logic [2:0] dbg_state;
    int         total;
    int         bad;
    bit         aborted;

    icache_dm_burst_if #(.ADDR_WIDTH(16)) bus ();

    icache_dm_burst #(
        .ADDR_WIDTH(16),
        .INDEX_BITS(6),
        .WORD_BITS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .busy       (busy),
        .o_dbg_state(dbg_state),
        .bus        (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in the first cycle of a sweep; returns in the first LOOKUP cycle.
    task automatic sweep_wait(input logic [2:0] st);
        check("sweep_state0", {29'd0, dbg_state}, {29'd0, st});
        check("sweep_busy_rdy0", {busy, bus.cache_ready_out}, 2'b10);
        for (int i = 1; i < 64; i++) begin
            tick();
            check("sweep_busy_rdy", {busy, bus.cache_ready_out}, 2'b10);
        end
        tick();
        check("sweep_done_state", {29'd0, dbg_state}, {29'd0, ST_LOOKUP});
        check("sweep_done_busy_rdy", {busy, bus.cache_ready_out}, 2'b01);
    endtask

    // Memory driver. Called in the miss-detect cycle. waits holds four 4-bit
    // wait counts (word 0 in the top nibble). flush_word/rst_word select the
    // word during which a flush pulse or a reset is applied (-1 = never).
    task automatic serve_refill(input logic [13:0] base, input logic [127:0] data,
                                input logic [15:0] waits, input bit stray,
                                input int flush_word, input int rst_word,
                                output bit was_reset);
        int n;
        logic [13:0] exp_addr;
        was_reset = 1'b0;
        if (stray) begin
            bus.memory_ack  = 1'b1;
            bus.memory_data = 32'hDEAD_BEEF;
        end
        n = 0;
        while (!bus.memory_stb && n < 20) begin
            tick();
            bus.memory_ack = 1'b0;
            n++;
        end
        check("stb_rise", {31'd0, bus.memory_stb}, 32'd1);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < int'(waits[15-4*w -: 4]); k++) begin
                bus.memory_ack = 1'b0;
                tick();
                check("stb_hold", {31'd0, bus.memory_stb}, 32'd1);
            end
            exp_addr = base + 14'(w);
            check("mem_addr", {18'd0, bus.memory_addr}, {18'd0, exp_addr});
            if (rst_word == w) begin
                bus.memory_ack = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_stb_drop", {31'd0, bus.memory_stb}, 32'd0);
                check("rst_state", {29'd0, dbg_state}, {29'd0, ST_INIT});
                was_reset = 1'b1;
                break;
            end
            bus.memory_ack  = 1'b1;
            bus.memory_data = data[127-32*w -: 32];
            if (flush_word == w) flush = 1'b1;
            tick();
            if (flush_word == w) begin
                flush = 1'b0;
                check("flush_busy", {31'd0, busy}, 32'd1);
            end
        end
        if (!was_reset) begin
            bus.memory_ack = 1'b0;
            check("replay_state", {29'd0, dbg_state}, {29'd0, ST_REPLAY});
            check("stb_drop", {31'd0, bus.memory_stb}, 32'd0);
            check("replay_vout", {31'd0, bus.cache_valid_out}, 32'd0);
        end
    endtask

    task automatic expect_hit(input string tag, input logic [7:0] b);
        check({tag, "_vout"}, {31'd0, bus.cache_valid_out}, 32'd1);
        check({tag, "_data"}, {24'd0, bus.cache_data_out}, {24'd0, b});
        check({tag, "_stb"}, {31'd0, bus.memory_stb}, 32'd0);
    endtask

    task automatic expect_miss(input string tag);
        check({tag, "_vout"}, {31'd0, bus.cache_valid_out}, 32'd0);
        check({tag, "_rdy"}, {31'd0, bus.cache_ready_out}, 32'd0);
        check({tag, "_stb"}, {31'd0, bus.memory_stb}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.cache_valid_in = 1'b0;
        bus.cache_addr_in  = '0;
        bus.cache_ready_in = 1'b0;
        bus.memory_ack     = 1'b0;
        bus.memory_data    = '0;
        repeat (3) @(posedge clk);
        #1;

        // reset values
        check("rst_rdy",   {31'd0, bus.cache_ready_out}, 32'd0);
        check("rst_vout",  {31'd0, bus.cache_valid_out}, 32'd0);
        check("rst_stb",   {31'd0, bus.memory_stb}, 32'd0);
        check("rst_maddr", {18'd0, bus.memory_addr}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd1);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_INIT});

        // INIT sweep, then first miss on 0x1234
        rst_n = 1'b1;
        bus.cache_valid_in = 1'b1;
        bus.cache_addr_in  = 16'h1234;
        bus.cache_ready_in = 1'b1;
        sweep_wait(ST_INIT);
        tick();
        expect_miss("miss1");
        tick();
        check("refill_state", {29'd0, dbg_state}, {29'd0, ST_REFILL});
        serve_refill(14'h48C, {32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3},
                     16'h0000, 1'b0, -1, -1, aborted);
        tick();
        expect_hit("fill1", 8'hB0);

        // back-to-back hits; stray acks with stb=0 must not write the array
        bus.cache_addr_in = 16'h1235;
        bus.memory_ack    = 1'b1;
        bus.memory_data   = 32'hFFFF_FFFF;
        tick();
        expect_hit("hit_1235", 8'hB1);
        bus.cache_addr_in = 16'h1236;
        tick();
        expect_hit("hit_1236", 8'hB2);
        // consumer stall holds the byte
        bus.cache_addr_in  = 16'h1237;
        bus.cache_ready_in = 1'b0;
        #1;
        check("stall_rdy", {31'd0, bus.cache_ready_out}, 32'd0);
        tick();
        expect_hit("stall1", 8'hB2);
        tick();
        expect_hit("stall2", 8'hB2);
        bus.cache_ready_in = 1'b1;
        tick();
        expect_hit("hit_1237", 8'hB3);
        bus.cache_addr_in = 16'h1238;
        tick();
        expect_hit("hit_1238", 8'hC0);
        bus.cache_addr_in = 16'h1230;
        tick();
        expect_hit("hit_1230", 8'hA0);
        bus.memory_ack = 1'b0;

        // conflict on index 0x23, irregular wait states and a stray ack
        bus.cache_addr_in = 16'h5234;
        tick();
        expect_miss("miss_5234");
        serve_refill(14'h148C, {32'h10111213, 32'h20212223, 32'h30313233, 32'h40414243},
                     16'h2051, 1'b1, -1, -1, aborted);
        tick();
        expect_hit("fill_5234", 8'h20);
        bus.cache_addr_in = 16'h5233;
        tick();
        expect_hit("hit_5233", 8'h13);
        bus.cache_addr_in = 16'h1234;
        tick();
        expect_miss("conflict_1234");

        // flush pulsed during the refill of word 1
        serve_refill(14'h48C, {32'h50515253, 32'h60616263, 32'h70717273, 32'h80818283},
                     16'h0304, 1'b1, 1, -1, aborted);
        tick();
        expect_hit("flush_drain", 8'h60);
        check("flush_drain_rdy", {31'd0, bus.cache_ready_out}, 32'd0);
        check("flush_drain_busy", {31'd0, busy}, 32'd1);
        tick();
        check("flush_empty_vout", {31'd0, bus.cache_valid_out}, 32'd0);
        check("flush_empty_state", {29'd0, dbg_state}, {29'd0, ST_LOOKUP});
        check("flush_empty_busy", {31'd0, busy}, 32'd1);
        tick();
        sweep_wait(ST_FLUSH);
        tick();
        expect_miss("post_flush_miss");
        serve_refill(14'h48C, {32'h90919293, 32'h94959697, 32'h98999A9B, 32'h9C9D9E9F},
                     16'h1111, 1'b1, -1, -1, aborted);
        tick();
        expect_hit("fill3", 8'h94);

        // reset during the second refill word
        bus.cache_addr_in = 16'h5237;
        tick();
        expect_miss("miss_5237");
        serve_refill(14'h148C, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                     16'h0000, 1'b0, -1, 1, aborted);
        check("reset_taken", {31'd0, aborted}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.cache_addr_in = 16'h1234;
        sweep_wait(ST_INIT);
        tick();
        expect_miss("post_reset_miss");
        serve_refill(14'h48C, {32'hC1C2C3C4, 32'hD1D2D3D4, 32'hE1E2E3E4, 32'hF1F2F3F4},
                     16'h0000, 1'b0, -1, -1, aborted);
        tick();
        expect_hit("fill4", 8'hD1);
        bus.cache_addr_in = 16'h1237;
        tick();
        expect_hit("lane3", 8'hD4);
        bus.cache_valid_in = 1'b0;
        tick();
        check("idle_vout", {31'd0, bus.cache_valid_out}, 32'd0);
        check("idle_rdy",  {31'd0, bus.cache_ready_out}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
